// File: rtl/restoring_divider_8by4_pkg.sv
// Shared definitions for the 8-by-4 restoring divider: FSM encoding and default operand widths.
package restoring_divider_8by4_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_divider_8by4_cond_subtractor.sv
// Trial subtract with restore: ripple of full adders computing a - b, muxed back to a on borrow.
module FullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module cond_subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y,
    output logic         o_ge
);
    logic [W:0]   w_c;
    logic [W-1:0] w_d;

    // a + ~b + 1; a final carry of 1 means no borrow, i.e. a >= b
    assign w_c[0] = 1'b1;

    for (genvar g = 0; g < W; g++) begin : g_fa
        FullAdder u_fa (
            .i_a    (i_a[g]),
            .i_b    (~i_b[g]),
            .i_cin  (w_c[g]),
            .o_sum  (w_d[g]),
            .o_cout (w_c[g+1])
        );
    end

    assign o_ge = w_c[W];
    assign o_y  = o_ge ? w_d : i_a;
endmodule

// File: rtl/restoring_divider_8by4.sv
// Sequential restoring divider: one quotient bit per RUN cycle, results registered at DONE.
module restoring_divider_8by4
    import restoring_divider_8by4_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int RW    = DIVISOR_W + 1;

    div_state_t            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [RW-1:0]         r_prem;
    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;

    logic [RW-1:0]         w_shift;
    logic [RW-1:0]         w_rem;
    logic                  w_ge;
    logic [DIVIDEND_W-1:0] w_quo_next;
    logic                  w_unused;

    // Partial remainder is always below the divisor, so its top bit is zero before the shift
    assign w_shift    = {r_prem[DIVISOR_W-1:0], r_dvd[DIVIDEND_W-1]};
    assign w_quo_next = {r_quo[DIVIDEND_W-2:0], w_ge};
    assign w_unused   = r_prem[DIVISOR_W];

    cond_subtractor #(.W(RW)) u_csub (
        .i_a  (w_shift),
        .i_b  ({1'b0, r_dvs}),
        .o_y  (w_rem),
        .o_ge (w_ge)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_dvd       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_prem  <= '0;
                        r_quo   <= '0;
                        r_count <= CNT_W'(DIVIDEND_W);
                        r_busy  <= 1'b1;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_dvd   <= r_dvd << 1;
                    r_prem  <= w_rem;
                    r_quo   <= w_quo_next;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem[DIVISOR_W-1:0];
                        r_dbz       <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
